pmod_cmd_bridge: RTL and testbench
==================================

// Module: pmod_cmd_bridge
// PURPOSE
//  Upstream command stage of the 64-bit AXI master bus interface. Parses byte frames from the Pmod link
//  receiver and issues single read_req/write_req bursts. Buffers write beats and returns read data and
//  status bytes to the link transmitter. Handles one frame at a time.
// PARAMETERS
//  MAX_BEATS    4     beat buffer depth (64-bit beats); longer bursts are rejected
//  TIMEOUT_CYC  4096  idle cycles allowed between frame bytes (only with BRIDGE_TIMEOUT_EN)
// PORTS
//  ACLK       in   1   clock
//  ARESET     in   1   asynchronous reset, active-high
//  rx_valid   in   1   link byte valid
//  rx_data    in   8   link byte
//  rx_ready   out  1   bridge accepts rx byte
//  tx_valid   out  1   response byte valid
//  tx_data    out  8   response byte
//  tx_ready   in   1   link accepts tx byte
//  write_req  out  1   one-cycle burst write request
//  read_req   out  1   one-cycle burst read request
//  busy       in   1   bus interface stall
//  len        out  10  length code (1,2,4,6->8 bytes; 8n -> 8(n+1) bytes)
//  address    out  32  byte address
//  wdata      out  64  current write beat
//  rvalid     in   1   read beat strobe (one per beat, alongside rdata)
//  rdata      in   64  read beat
//  rlast      in   1   last read beat
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. ARESET mid-frame aborts everything; no response is sent.
//  Frame: op(1) len(2, LE, bits[15:10] ignored) addr(4, LE) [write data: beats*8 bytes, LE per beat].
//  op 0x01 = write, 0x02 = read; any other op -> ERR.
//  beats = (len[2:0]!=0) ? 1 : len[9:3]+1. If beats > MAX_BEATS -> ERR after header, no bus request.
//  rx_ready=1 only in IDLE/HDR/WDATA; a byte is consumed when rx_valid&rx_ready.
//  FSM: IDLE -(op byte)-> HDR -(6 bytes)-> WDATA (write) | RISSUE (read) | ERR.
//   WDATA: packs 8 bytes per beat into buf[i]; after the last byte -> WISSUE.
//   WISSUE: write_req=1 for one cycle, wdata=buf[0]; -> WDRAIN with idx=1.
//   WDRAIN: wdata=buf[idx]; each cycle with busy==0 counts one accepted beat, idx++; after `beats` counted -> ACK.
//   RISSUE: read_req=1 for one cycle; -> RWAIT. RWAIT: each rvalid stores rdata at buf[idx++]; rvalid&rlast -> RSEND.
//   RSEND: sends 0xA5, then beats*8 data bytes, LSB first -> IDLE.
//   ACK: sends 0x5A -> IDLE. ERR: sends 0xEE -> IDLE.
//  tx_valid holds with a stable tx_data until tx_ready; one byte per handshake, no bubbles required.
//  Extra rvalid beats beyond MAX_BEATS are dropped (idx saturates); rlast still ends RWAIT.
//  len/address hold their values from HDR until the next frame; write_req and read_req are never high together.
// CONFIGURATION
//  BRIDGE_TIMEOUT_EN defined: in HDR/WDATA, a counter clears on each rx byte. When TIMEOUT_CYC cycles pass
//   with no byte -> ERR (0xEE), and the partial frame is discarded.
//  Undefined: no counter, and a frame waits for its next byte indefinitely.
// STRUCTURE
//  pmod_bridge_pkg: OP_WRITE/OP_READ, RSP_RD=8'hA5, RSP_ACK=8'h5A, RSP_ERR=8'hEE, state_t enum,
//   function beats_of(len).
//  Sub-module pmod_beat_buf: MAX_BEATS x 64 register file. It has a byte-lane write port (for rx packing),
//   a beat write port (for rdata), and a beat read port with a byte select (for tx and wdata).
// TESTING
//  Write len=4 addr=0x1000 data 8B -> one write_req, len=4, address=0x1000, wdata=byte-packed beat, then tx 0x5A.
//  Write len=8 (2 beats), busy high 3 cycles after req -> wdata stays buf[1] through the stall; ack after 2 non-busy cycles.
//  Read len=16 (3 beats), rvalid x3 with rlast on 3rd -> tx 0xA5 + 24 bytes in order; tx_ready toggled 50%.
//  Op 0x07 -> tx 0xEE, no write_req/read_req, next valid frame works.
//  Read len=64 (9 beats > 4) -> 0xEE, no read_req.
//  ARESET during WDATA -> outputs 0, idle, next frame completes normally.
//  Timeout (macro on) 4096 idle cycles mid-header -> 0xEE; with the macro off, the frame completes after the gap.

Source files
------------

// File: rtl/pmod_bridge_pkg.sv
// Shared opcodes, response bytes, FSM states and burst-length decode for the Pmod command bridge.
package pmod_bridge_pkg;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam logic [7:0] RSP_RD   = 8'hA5;
   localparam logic [7:0] RSP_ACK  = 8'h5A;
   localparam logic [7:0] RSP_ERR  = 8'hEE;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_WDATA, S_WISSUE, S_WDRAIN,
      S_RISSUE, S_RWAIT, S_RSEND, S_ACK, S_ERR
   } state_t;

   // Any sub-beat length is a single beat; otherwise len/8 + 1 beats.
   function automatic logic [7:0] beats_of(input logic [9:0] len);
      logic [7:0] b;
      b = (len[2:0] != 3'd0) ? 8'd1 : ({1'b0, len[9:3]} + 8'd1);
      return b;
   endfunction

endpackage

// File: rtl/pmod_beat_buf.sv
// MAX_BEATS x 64-bit beat store: byte-lane write for rx packing, beat write for read data,
// and one beat read port with a byte select for tx and wdata.
module pmod_beat_buf #(
   parameter int MAX_BEATS = 4,
   parameter int IW        = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_bw_en,
   input  logic [IW-1:0] i_bw_beat,
   input  logic [2:0]    i_bw_lane,
   input  logic [7:0]    i_bw_data,
   input  logic          i_w_en,
   input  logic [IW-1:0] i_w_beat,
   input  logic [63:0]   i_w_data,
   input  logic [IW-1:0] i_r_beat,
   input  logic [2:0]    i_r_lane,
   output logic [63:0]   o_r_beat,
   output logic [7:0]    o_r_byte
);

   logic [MAX_BEATS-1:0][63:0] r_mem;
   logic [63:0]                w_beat;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem <= '0;
      end else begin
         for (int i = 0; i < MAX_BEATS; i++) begin
            if (i_w_en && (i_w_beat == IW'(i)))
               r_mem[i] <= i_w_data;
            else if (i_bw_en && (i_bw_beat == IW'(i)))
               r_mem[i][{i_bw_lane, 3'b000} +: 8] <= i_bw_data;
         end
      end
   end

   // Out-of-range beat indices read as zero.
   always_comb begin
      w_beat = '0;
      for (int i = 0; i < MAX_BEATS; i++)
         if (i_r_beat == IW'(i)) w_beat = r_mem[i];
   end

   assign o_r_beat = w_beat;
   assign o_r_byte = w_beat[{i_r_lane, 3'b000} +: 8];

endmodule

// File: rtl/pmod_cmd_bridge.sv
// Pmod byte-frame parser issuing single AXI read/write bursts and returning status/read bytes.
// Optional inter-byte timeout enabled with `define BRIDGE_TIMEOUT_EN.
module pmod_cmd_bridge
   import pmod_bridge_pkg::*;
#(
   parameter int MAX_BEATS = 4
`ifdef BRIDGE_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 4096
`endif
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        write_req,
   output logic        read_req,
   input  logic        busy,
   output logic [9:0]  len,
   output logic [31:0] address,
   output logic [63:0] wdata,
   input  logic        rvalid,
   input  logic [63:0] rdata,
   input  logic        rlast
);

   localparam int IW = $clog2(MAX_BEATS + 1);
   localparam int BW = IW + 3;

   state_t        r_state;
   logic [7:0]    r_op;
   logic [2:0]    r_hcnt;
   logic [9:0]    r_len;
   logic [31:0]   r_addr;
   logic [IW-1:0] r_beats;
   logic [IW-1:0] r_idx;
   logic [BW-1:0] r_bcnt;
   logic          r_rx_ready;
   logic          r_tx_valid;
   logic [7:0]    r_tx_data;
   logic          r_wr_req;
   logic          r_rd_req;
`ifdef BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_to;
`endif

   logic          w_rx_fire;
   logic          w_tx_fire;
   logic [7:0]    w_beats;
   logic          w_hdr_bad;
   logic [BW-1:0] w_total;
   logic [IW-1:0] w_rd_beat;
   logic [63:0]   w_rd_data;
   logic [7:0]    w_rd_byte;
   logic          w_bw_en;
   logic          w_w_en;

   assign w_rx_fire = rx_valid & r_rx_ready;
   assign w_tx_fire = r_tx_valid & tx_ready;
   assign w_beats   = beats_of(r_len);
   assign w_hdr_bad = ((r_op != OP_WRITE) && (r_op != OP_READ)) || (w_beats > 8'(MAX_BEATS));
   assign w_total   = {r_beats, 3'b000};
   // r_bcnt walks the byte stream while sending read data; otherwise r_idx picks the beat.
   assign w_rd_beat = (r_state == S_RSEND) ? r_bcnt[BW-1:3] : r_idx;
   assign w_bw_en   = (r_state == S_WDATA) && w_rx_fire;
   assign w_w_en    = (r_state == S_RWAIT) && rvalid && (r_idx < IW'(MAX_BEATS));

   pmod_beat_buf #(.MAX_BEATS(MAX_BEATS), .IW(IW)) u_buf (
      .i_clk     (ACLK),
      .i_rst     (ARESET),
      .i_bw_en   (w_bw_en),
      .i_bw_beat (r_bcnt[BW-1:3]),
      .i_bw_lane (r_bcnt[2:0]),
      .i_bw_data (rx_data),
      .i_w_en    (w_w_en),
      .i_w_beat  (r_idx),
      .i_w_data  (rdata),
      .i_r_beat  (w_rd_beat),
      .i_r_lane  (r_bcnt[2:0]),
      .o_r_beat  (w_rd_data),
      .o_r_byte  (w_rd_byte)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_hcnt     <= '0;
         r_len      <= '0;
         r_addr     <= '0;
         r_beats    <= '0;
         r_idx      <= '0;
         r_bcnt     <= '0;
         r_rx_ready <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_wr_req   <= 1'b0;
         r_rd_req   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
         r_to       <= '0;
`endif
      end else begin
         r_wr_req <= 1'b0;
         r_rd_req <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_rx_ready <= 1'b1;
               if (w_rx_fire) begin
                  r_op    <= rx_data;
                  r_hcnt  <= '0;
                  r_state <= S_HDR;
               end
            end
            S_HDR: if (w_rx_fire) begin
               case (r_hcnt)
                  3'd0:    r_len[7:0]     <= rx_data;
                  3'd1:    r_len[9:8]     <= rx_data[1:0];
                  3'd2:    r_addr[7:0]    <= rx_data;
                  3'd3:    r_addr[15:8]   <= rx_data;
                  3'd4:    r_addr[23:16]  <= rx_data;
                  3'd5:    r_addr[31:24]  <= rx_data;
                  default: ;
               endcase
               r_hcnt <= r_hcnt + 3'd1;
               if (r_hcnt == 3'd5) begin
                  r_bcnt  <= '0;
                  r_idx   <= '0;
                  r_beats <= w_beats[IW-1:0];
                  if (w_hdr_bad) begin
                     r_state    <= S_ERR;
                     r_tx_valid <= 1'b1;
                     r_tx_data  <= RSP_ERR;
                     r_rx_ready <= 1'b0;
                  end else if (r_op == OP_WRITE) begin
                     r_state <= S_WDATA;
                  end else begin
                     r_state    <= S_RISSUE;
                     r_rd_req   <= 1'b1;
                     r_rx_ready <= 1'b0;
                  end
               end
            end
            S_WDATA: if (w_rx_fire) begin
               r_bcnt <= r_bcnt + BW'(1);
               if (r_bcnt == w_total - BW'(1)) begin
                  r_state    <= S_WISSUE;
                  r_wr_req   <= 1'b1;
                  r_rx_ready <= 1'b0;
               end
            end
            S_WISSUE: begin
               r_state <= S_WDRAIN;
               r_idx   <= IW'(1);
               r_bcnt  <= '0;
            end
            S_WDRAIN: if (!busy) begin
               if (r_idx < IW'(MAX_BEATS)) r_idx <= r_idx + IW'(1);
               if (r_bcnt + BW'(1) == BW'(r_beats)) begin
                  r_state    <= S_ACK;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= RSP_ACK;
               end else begin
                  r_bcnt <= r_bcnt + BW'(1);
               end
            end
            S_RISSUE: begin
               r_state <= S_RWAIT;
               r_idx   <= '0;
            end
            S_RWAIT: if (rvalid) begin
               if (r_idx < IW'(MAX_BEATS)) r_idx <= r_idx + IW'(1);
               if (rlast) begin
                  r_state    <= S_RSEND;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= RSP_RD;
                  r_bcnt     <= '0;
               end
            end
            // r_bcnt is the index of the next data byte to load behind the one on tx_data.
            S_RSEND: if (w_tx_fire) begin
               if (r_bcnt == w_total) begin
                  r_state    <= S_IDLE;
                  r_tx_valid <= 1'b0;
                  r_rx_ready <= 1'b1;
               end else begin
                  r_tx_data <= w_rd_byte;
                  r_bcnt    <= r_bcnt + BW'(1);
               end
            end
            S_ACK, S_ERR: if (w_tx_fire) begin
               r_state    <= S_IDLE;
               r_tx_valid <= 1'b0;
               r_rx_ready <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef BRIDGE_TIMEOUT_EN
         if ((r_state == S_HDR) || (r_state == S_WDATA)) begin
            if (w_rx_fire) begin
               r_to <= '0;
            end else if (r_to == TW'(TIMEOUT_CYC - 1)) begin
               r_state    <= S_ERR;
               r_tx_valid <= 1'b1;
               r_tx_data  <= RSP_ERR;
               r_rx_ready <= 1'b0;
            end else begin
               r_to <= r_to + TW'(1);
            end
         end else begin
            r_to <= '0;
         end
`endif
      end
   end

   assign rx_ready  = r_rx_ready;
   assign tx_valid  = r_tx_valid;
   assign tx_data   = r_tx_data;
   assign write_req = r_wr_req;
   assign read_req  = r_rd_req;
   assign len       = r_len;
   assign address   = r_addr;
   assign wdata     = w_rd_data;

endmodule

// File: tb/tb_pmod_cmd_bridge.sv
// Randomized frame-level bench for pmod_cmd_bridge with a byte/beat reference model.
module tb_pmod_cmd_bridge;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        write_req, read_req;
   logic        busy = 1'b0;
   logic [9:0]  len;
   logic [31:0] address;
   logic [63:0] wdata;
   logic        rvalid = 1'b0;
   logic [63:0] rdata = 64'h0;
   logic        rlast = 1'b0;

   int tests = 0, fails = 0;
   int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, hold_viol = 0;
   bit tx_rand = 1'b0;
   bit hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;
   logic [7:0] txq[$];

   localparam int MAXB = 4;

   always #5 ACLK = ~ACLK;

   pmod_cmd_bridge dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .write_req(write_req), .read_req(read_req), .busy(busy),
      .len(len), .address(address), .wdata(wdata),
      .rvalid(rvalid), .rdata(rdata), .rlast(rlast)
   );

   always @(negedge ACLK) tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;

   // Link-side observer: captures handshaken tx bytes, request pulses and tx hold behaviour.
   always @(posedge ACLK) begin
      if (!ARESET && hold_pend && (!tx_valid || tx_data !== hold_data)) hold_viol <= hold_viol + 1;
      hold_pend <= tx_valid && !tx_ready;
      hold_data <= tx_data;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (write_req) wr_cnt <= wr_cnt + 1;
      if (read_req) rd_cnt <= rd_cnt + 1;
      if (write_req && read_req) both_cnt <= both_cnt + 1;
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge ACLK);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 1000) begin @(negedge ACLK); n++; end
      if (!rx_ready) begin
         tests++; fails++;
         $display("FAIL rx_ready_timeout got=0 want=1");
      end
      @(posedge ACLK);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [9:0] l, input logic [31:0] a);
      send_byte(op);
      send_byte(l[7:0]);
      send_byte({6'($urandom), l[9:8]});
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
   endtask

   task automatic wait_tx(input int n);
      int c = 0;
      while (txq.size() < n && c < 2000) begin @(negedge ACLK); c++; end
      tests++;
      if (txq.size() < n) begin
         fails++;
         $display("FAIL tx_count got=%0d want=%0d", txq.size(), n);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge ACLK);
      tests++;
      if ({rx_ready, tx_valid, write_req, read_req} !== 4'b0) begin
         fails++; $display("FAIL reset_ctrl got=%b want=0000", {rx_ready, tx_valid, write_req, read_req});
      end
      tests++;
      if (tx_data !== 8'h00 || len !== 10'h0 || address !== 32'h0 || wdata !== 64'h0) begin
         fails++; $display("FAIL reset_data got=%h/%h/%h/%h want=0", tx_data, len, address, wdata);
      end
      ARESET = 1'b0;
      repeat (2) @(negedge ACLK);
      tests++;
      if (rx_ready !== 1'b1) begin fails++; $display("FAIL idle_rx_ready got=%b want=1", rx_ready); end
   endtask

   task automatic test_write_single(input logic [31:0] a);
      logic [7:0]  d [8];
      logic [63:0] exp_beat;
      int w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      txq.delete();
      for (int i = 0; i < 8; i++) begin d[i] = 8'($urandom); exp_beat[8*i +: 8] = d[i]; end
      send_hdr(8'h01, 10'd4, a);
      for (int i = 0; i < 8; i++) send_byte(d[i]);
      @(negedge ACLK);
      tests++;
      if (write_req !== 1'b1 || read_req !== 1'b0) begin
         fails++; $display("FAIL wr_req got=%b%b want=10", write_req, read_req);
      end
      tests++;
      if (len !== 10'd4 || address !== a) begin
         fails++; $display("FAIL wr_hdr got=%0d/%h want=4/%h", len, address, a);
      end
      tests++;
      if (wdata !== exp_beat) begin fails++; $display("FAIL wr_wdata got=%h want=%h", wdata, exp_beat); end
      wait_tx(1);
      tests++;
      if (txq.size() < 1 || txq[0] !== 8'h5A) begin
         fails++; $display("FAIL wr_ack got=%h want=5a", (txq.size() > 0) ? txq[0] : 8'hxx);
      end
      tests++;
      if (wr_cnt - w0 != 1 || rd_cnt != r0) begin
         fails++; $display("FAIL wr_req_count got=%0d/%0d want=1/0", wr_cnt - w0, rd_cnt - r0);
      end
   endtask

   task automatic test_write_stall();
      logic [7:0]  d [16];
      logic [63:0] b0, b1;
      logic [31:0] a;
      int c;
      a = $urandom & 32'hFFFF_FFF0;
      txq.delete();
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin b0[8*i +: 8] = d[i]; b1[8*i +: 8] = d[8+i]; end
      send_hdr(8'h01, 10'd8, a);
      for (int i = 0; i < 16; i++) send_byte(d[i]);
      @(negedge ACLK);
      busy = 1'b1;
      tests++;
      if (write_req !== 1'b1 || wdata !== b0) begin
         fails++; $display("FAIL stall_issue got=%b/%h want=1/%h", write_req, wdata, b0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK);
         tests++;
         if (wdata !== b1 || write_req !== 1'b0) begin
            fails++; $display("FAIL stall_wdata[%0d] got=%h want=%h", k, wdata, b1);
         end
      end
      busy = 1'b0;
      c = 0;
      while (!tx_valid && c < 20) begin @(negedge ACLK); c++; end
      tests++;
      if (c != 2) begin fails++; $display("FAIL stall_ack_latency got=%0d want=2", c); end
      wait_tx(1);
      tests++;
      if (txq.size() < 1 || txq[0] !== 8'h5A) begin fails++; $display("FAIL stall_ack got=%h want=5a", txq[0]); end
   endtask

   task automatic test_read(input int nb, input int nrv, input logic [9:0] l);
      logic [63:0] mem[$];
      logic [63:0] beat;
      logic [7:0]  exp_q[$];
      logic [31:0] a;
      int r0;
      a = $urandom;
      r0 = rd_cnt;
      txq.delete();
      tx_rand = 1'b1;
      send_hdr(8'h02, l, a);
      @(negedge ACLK);
      tests++;
      if (read_req !== 1'b1 || write_req !== 1'b0 || len !== l || address !== a) begin
         fails++; $display("FAIL rd_issue got=%b%b/%0d/%h want=01/%0d/%h", read_req, write_req, len, address, l, a);
      end
      @(negedge ACLK);
      for (int k = 0; k < nrv; k++) begin
         beat = {$urandom, $urandom};
         if (mem.size() < MAXB) mem.push_back(beat);
         rvalid = 1'b1; rdata = beat; rlast = (k == nrv - 1);
         @(negedge ACLK);
         rvalid = 1'b0; rlast = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge ACLK);
      end
      exp_q.push_back(8'hA5);
      for (int b = 0; b < nb; b++)
         for (int j = 0; j < 8; j++) exp_q.push_back(mem[b][8*j +: 8]);
      wait_tx(exp_q.size());
      repeat (5) @(negedge ACLK);
      tests++;
      if (txq.size() != exp_q.size()) begin
         fails++; $display("FAIL rd_len got=%0d want=%0d", txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         tests++;
         if (txq[i] !== exp_q[i]) begin fails++; $display("FAIL rd_byte[%0d] got=%h want=%h", i, txq[i], exp_q[i]); end
      end
      tests++;
      if (rd_cnt - r0 != 1 || both_cnt != 0 || hold_viol != 0) begin
         fails++; $display("FAIL rd_proto got=%0d/%0d/%0d want=1/0/0", rd_cnt - r0, both_cnt, hold_viol);
      end
      tx_rand = 1'b0;
   endtask

   task automatic test_bad_op();
      int w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      txq.delete();
      send_hdr(8'h07, 10'd4, $urandom);
      wait_tx(1);
      repeat (4) @(negedge ACLK);
      tests++;
      if (txq.size() != 1 || txq[0] !== 8'hEE) begin
         fails++; $display("FAIL badop_rsp got=%h(n=%0d) want=ee(n=1)", txq[0], txq.size());
      end
      tests++;
      if (wr_cnt != w0 || rd_cnt != r0) begin fails++; $display("FAIL badop_req got=%0d/%0d want=0/0", wr_cnt - w0, rd_cnt - r0); end
      test_write_single($urandom);
   endtask

   task automatic test_oversize();
      int r0;
      r0 = rd_cnt;
      txq.delete();
      send_hdr(8'h02, 10'd64, 32'h0000_2000);
      wait_tx(1);
      tests++;
      if (txq[0] !== 8'hEE || rd_cnt != r0) begin
         fails++; $display("FAIL oversize got=%h/%0d want=ee/0", txq[0], rd_cnt - r0);
      end
      tests++;
      if (len !== 10'd64) begin fails++; $display("FAIL oversize_len got=%0d want=64", len); end
   endtask

   task automatic test_reset_mid();
      int w0;
      w0 = wr_cnt;
      txq.delete();
      send_hdr(8'h01, 10'd8, 32'hCAFE_0040);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      @(negedge ACLK);
      ARESET = 1'b1;
      @(negedge ACLK);
      tests++;
      if (len !== 10'h0 || address !== 32'h0 || wdata !== 64'h0 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
         fails++; $display("FAIL midreset got=%h/%h/%h/%b/%b want=0", len, address, wdata, rx_ready, tx_valid);
      end
      ARESET = 1'b0;
      repeat (6) @(negedge ACLK);
      tests++;
      if (txq.size() != 0 || wr_cnt != w0) begin
         fails++; $display("FAIL midreset_quiet got=%0d/%0d want=0/0", txq.size(), wr_cnt - w0);
      end
      test_write_single(32'h0000_1000);
   endtask

   task automatic test_timeout();
      int w0;
      w0 = wr_cnt;
      txq.delete();
      send_byte(8'h01);
      send_byte(8'h04);
      send_byte(8'h00);
      repeat (4200) @(negedge ACLK);
`ifdef BRIDGE_TIMEOUT_EN
      wait_tx(1);
      tests++;
      if (txq[0] !== 8'hEE || wr_cnt != w0) begin
         fails++; $display("FAIL timeout_err got=%h/%0d want=ee/0", txq[0], wr_cnt - w0);
      end
`else
      tests++;
      if (txq.size() != 0) begin fails++; $display("FAIL gap_quiet got=%0d want=0", txq.size()); end
      for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
      for (int i = 0; i < 8; i++) send_byte(8'(i));
      @(negedge ACLK);
      tests++;
      if (write_req !== 1'b1 || address !== 32'h1312_1110 || wdata !== 64'h0706_0504_0302_0100) begin
         fails++; $display("FAIL gap_write got=%b/%h/%h want=1/13121110/0706050403020100", write_req, address, wdata);
      end
      wait_tx(1);
      tests++;
      if (txq[0] !== 8'h5A) begin fails++; $display("FAIL gap_ack got=%h want=5a", txq[0]); end
`endif
   endtask

   initial begin
      int nb, nrv;
      logic [9:0] l;
      test_reset();
      test_write_single(32'h0000_1000);
      test_write_stall();
      test_read(3, 3, 10'd16);
      test_read(4, 6, 10'd24);
      for (int t = 0; t < 3; t++) begin
         nb  = $urandom_range(1, MAXB);
         nrv = nb + $urandom_range(0, 2);
         l   = (nb == 1) ? 10'($urandom_range(0, 7)) : 10'(8 * (nb - 1));
         test_read(nb, nrv, l);
      end
      test_bad_op();
      test_oversize();
      test_reset_mid();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
